// File: rtl/fsm_key_pkg.sv
// rtl/fsm_key_pkg.sv - shared types and helpers for the key sequencer
//
// Purpose: state encoding, symbol type, key symbol extraction and the width
// helper used to size key_idx, fail_cnt and the lockout timer.
package fsm_key_pkg;

  typedef enum logic [1:0] {
    ST_SEEK     = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  typedef logic [1:0] sym_t;

  // Symbol idx of a key packed LSB-first, two bits per symbol (up to 8 symbols).
  // Constant-index loop keeps the select width-clean for any idx.
  function automatic sym_t key_sym(input logic [15:0] key, input int idx);
    sym_t s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == idx) s = key[2*i +: 2];
    end
    return s;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsm_key_timer.sv
// rtl/fsm_key_timer.sv - loadable down-counter with zero flag
//
// Purpose: times the lockout interval.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val this cycle (wins over dec)
//   load_val    value to load
//   dec         decrement by one; holds at zero
//   zero        count is zero
module fsm_key_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fsm_key_sequencer.sv
// rtl/fsm_key_sequencer.sv - unlock-key gate for the guarded 2-input FSM
//
// Purpose: watches {in1,in0} for a KEY_LEN-symbol key; on a match clears the
// guarded FSM and passes in_valid through as its step enable; repeated broken
// attempts force a LOCK_CYCLES lockout.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     in0/in1 carry a symbol
//   in0, in1     symbol bits 0 and 1
//   relock       return to the locked (SEEK) state
//   fsm_en       step enable to the guarded FSM (combinational)
//   fsm_clr      one-cycle clear of the guarded FSM state
//   unlocked     state is UNLOCKED (registered)
//   lockout      state is LOCKOUT (registered)
//   key_idx      next expected key symbol index
//   fail_cnt     broken-sequence count
module fsm_key_sequencer
  import fsm_key_pkg::*;
#(
  parameter int                   KEY_LEN     = 4,
  parameter logic [2*KEY_LEN-1:0] KEY         = 8'b00_11_01_10,
  parameter int                   MAX_FAIL    = 3,
  parameter int                   LOCK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in0,
  input  logic                           in1,
  input  logic                           relock,
  output logic                           fsm_en,
  output logic                           fsm_clr,
  output logic                           unlocked,
  output logic                           lockout,
  output logic [idx_w(KEY_LEN)-1:0]      key_idx,
  output logic [idx_w(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int          KIW   = idx_w(KEY_LEN);
  localparam int          FCW   = idx_w(MAX_FAIL + 1);
  localparam int          TW    = idx_w(LOCK_CYCLES);
  localparam logic [15:0] KEY16 = 16'(KEY);

  state_t         state, state_nxt;
  logic [KIW-1:0] idx_nxt;
  logic [FCW-1:0] fail_nxt;
  logic           tmr_load, tmr_zero;
  sym_t           sym, exp_sym, first_sym;
  logic           last_idx, fail_hit;

  assign sym       = {in1, in0};
  assign exp_sym   = key_sym(KEY16, int'(key_idx));
  assign first_sym = key_sym(KEY16, 0);
  assign last_idx  = (int'(key_idx) == KEY_LEN - 1);
  assign fail_hit  = (int'(fail_cnt) + 1 >= MAX_FAIL);

  fsm_key_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TW'(LOCK_CYCLES - 1)),
    .dec      (state == ST_LOCKOUT),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = key_idx;
    fail_nxt  = fail_cnt;
    tmr_load  = 1'b0;
    fsm_en    = 1'b0;
    case (state)
      ST_SEEK: begin
        if (relock) begin
          idx_nxt = '0;
        end else if (in_valid) begin
          if (sym == exp_sym) begin
            if (last_idx) begin
              state_nxt = ST_UNLOCKED;
              idx_nxt   = '0;
              fail_nxt  = '0;
            end else begin
              idx_nxt = key_idx + 1'b1;
            end
          end else if (key_idx != '0) begin
            if (fail_hit) begin
              // Timer starts at LOCK_CYCLES-1 so LOCKOUT lasts LOCK_CYCLES cycles
              state_nxt = ST_LOCKOUT;
              idx_nxt   = '0;
              fail_nxt  = FCW'(MAX_FAIL);
              tmr_load  = 1'b1;
            end else begin
              fail_nxt = fail_cnt + 1'b1;
              // The breaking symbol may itself open a new attempt
              idx_nxt  = (sym == first_sym) ? KIW'(1) : '0;
            end
          end
        end
      end
      ST_UNLOCKED: begin
        fsm_en = in_valid;
        if (relock) begin
          state_nxt = ST_SEEK;
          idx_nxt   = '0;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_zero) begin
          state_nxt = ST_SEEK;
          fail_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_SEEK;
        idx_nxt   = '0;
        fail_nxt  = '0;
      end
    endcase
  end

  // Status flags decode the next state so they line up with the state itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SEEK;
      key_idx  <= '0;
      fail_cnt <= '0;
      fsm_clr  <= 1'b0;
      unlocked <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      key_idx  <= idx_nxt;
      fail_cnt <= fail_nxt;
      fsm_clr  <= (state == ST_SEEK) && (state_nxt == ST_UNLOCKED);
      unlocked <= (state_nxt == ST_UNLOCKED);
      lockout  <= (state_nxt == ST_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_fsm_key_sequencer.sv
// tb/tb_fsm_key_sequencer.sv - self-checking bench for fsm_key_sequencer
module tb_fsm_key_sequencer;

  localparam int KEY_LEN     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in0 = 1'b0;
  logic       in1 = 1'b0;
  logic       relock = 1'b0;
  logic       fsm_en, fsm_clr, unlocked, lockout;
  logic [1:0] key_idx;
  logic [1:0] fail_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on = 1'b0;

  // Key symbols in arrival order: 10, 01, 11, 00
  int key_seq[KEY_LEN] = '{2, 1, 3, 0};

  // Model: mode 0=seek 1=unlocked 2=lockout
  int m_mode, m_prog, m_fails, m_left;
  bit m_clr;

  fsm_key_sequencer #(
    .KEY_LEN(KEY_LEN), .KEY(8'b00_11_01_10),
    .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in0(in0), .in1(in1),
    .relock(relock), .fsm_en(fsm_en), .fsm_clr(fsm_clr), .unlocked(unlocked),
    .lockout(lockout), .key_idx(key_idx), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prog = 0; m_fails = 0; m_left = 0; m_clr = 1'b0;
  endtask

  task automatic model_step();
    int s;
    s = {in1, in0};
    m_clr = 1'b0;
    case (m_mode)
      0: begin
        if (relock) m_prog = 0;
        else if (in_valid) begin
          if (s == key_seq[m_prog]) begin
            m_prog++;
            if (m_prog == KEY_LEN) begin
              m_mode = 1; m_prog = 0; m_fails = 0; m_clr = 1'b1;
            end
          end else if (m_prog > 0) begin
            m_fails++;
            if (m_fails >= MAX_FAIL) begin
              m_mode = 2; m_left = LOCK_CYCLES; m_prog = 0;
            end else begin
              m_prog = (s == key_seq[0]) ? 1 : 0;
            end
          end
        end
      end
      1: if (relock) begin m_mode = 0; m_prog = 0; end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_fails = 0; end
      end
    endcase
  endtask

  always @(posedge clk) if (rst_n) model_step();

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      check("unlocked", int'(unlocked), int'(m_mode == 1));
      check("lockout", int'(lockout), int'(m_mode == 2));
      check("key_idx", int'(key_idx), m_prog);
      check("fail_cnt", int'(fail_cnt), m_fails);
      check("fsm_clr", int'(fsm_clr), int'(m_clr));
      check("fsm_en", int'(fsm_en), int'((m_mode == 1) && in_valid));
    end
  end

  // One input cycle: drive, let the edge sample, return to idle at edge+1
  task automatic cyc(input bit v, input int s, input bit r);
    in_valid = v; {in1, in0} = 2'(s); relock = r;
    @(posedge clk); #1;
    in_valid = 1'b0; {in1, in0} = 2'b00; relock = 1'b0;
  endtask

  task automatic cyc_en(input bit v, input bit r, input int exp_en, input string name);
    in_valid = v; {in1, in0} = 2'b00; relock = r;
    #2;
    check(name, int'(fsm_en), exp_en);
    @(posedge clk); #1;
    in_valid = 1'b0; relock = 1'b0;
  endtask

  task automatic send_key();
    for (int i = 0; i < KEY_LEN; i++) cyc(1'b1, key_seq[i], 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_unlocked"}, int'(unlocked), 0);
    check({tag, "_lockout"}, int'(lockout), 0);
    check({tag, "_key_idx"}, int'(key_idx), 0);
    check({tag, "_fail_cnt"}, int'(fail_cnt), 0);
    check({tag, "_fsm_clr"}, int'(fsm_clr), 0);
    check({tag, "_fsm_en"}, int'(fsm_en), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    model_reset();
    @(posedge clk); #1;
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_lockout", int'(lockout), 0);
    check("rst_key_idx", int'(key_idx), 0);
    check("rst_fail_cnt", int'(fail_cnt), 0);
    check("rst_fsm_en", int'(fsm_en), 0);
    check("rst_fsm_clr", int'(fsm_clr), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_on = 1'b1;

    // Unlock with the correct key
    cyc(1, 2, 0); cyc(1, 1, 0); cyc(1, 3, 0);
    check("idx_after3", int'(key_idx), 3);
    cyc(1, 0, 0);
    check("unl_after_key", int'(unlocked), 1);
    check("clr_first_cycle", int'(fsm_clr), 1);
    check("fail_after_key", int'(fail_cnt), 0);
    cyc(0, 0, 0);
    check("clr_one_cycle", int'(fsm_clr), 0);

    // Pass-through enable, relock keeps enable for its own cycle
    cyc_en(1, 0, 1, "en_pulse1");
    cyc_en(0, 0, 0, "en_pulse0");
    cyc_en(1, 0, 1, "en_pulse2");
    cyc_en(1, 1, 1, "en_on_relock");
    check("relock_unl", int'(unlocked), 0);
    check("relock_idx", int'(key_idx), 0);
    cyc_en(1, 0, 0, "en_after_relock");

    // Broken attempts and restart on KEY[0]
    cyc(1, 2, 0); cyc(1, 3, 0);
    check("brk1_fail", int'(fail_cnt), 1);
    check("brk1_idx", int'(key_idx), 0);
    cyc(1, 2, 0); cyc(1, 2, 0);
    check("brk2_fail", int'(fail_cnt), 2);
    check("brk2_idx", int'(key_idx), 1);

    // relock in SEEK beats a same-cycle matching symbol
    cyc(1, 1, 1);
    check("seek_relock_idx", int'(key_idx), 0);
    check("seek_relock_fail", int'(fail_cnt), 2);

    // Reset mid-sequence, then the tail of the key alone must not unlock
    cyc(1, 2, 0); cyc(1, 1, 0);
    check("mid_idx", int'(key_idx), 2);
    async_reset_check("rst_mid_seq");
    cyc(1, 3, 0); cyc(1, 0, 0);
    check("tail_no_unlock", int'(unlocked), 0);

    // Three broken attempts -> lockout of exactly LOCK_CYCLES cycles
    for (int i = 0; i < 3; i++) begin cyc(1, 2, 0); cyc(1, 3, 0); end
    check("lock_on", int'(lockout), 1);
    check("lock_fail_sat", int'(fail_cnt), 3);
    cnt = 0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (lockout) cnt++;
      cyc(1, key_seq[i], (i == 1));
    end
    check("lock_key_ignored", int'(unlocked), 0);
    for (int b = 0; b < 40 && lockout; b++) begin
      cnt++;
      cyc(0, 0, 0);
    end
    check("lock_len", cnt, LOCK_CYCLES);
    check("lock_exit_fail", int'(fail_cnt), 0);
    send_key();
    check("unl_after_lock", int'(unlocked), 1);
    cyc(0, 0, 1);

    // Idle 00 stream with key_idx=0
    for (int i = 0; i < 50; i++) cyc(1, 0, 0);
    check("idle_fail", int'(fail_cnt), 0);
    check("idle_lock", int'(lockout), 0);

    // Reset mid-lockout
    for (int i = 0; i < 3; i++) begin cyc(1, 2, 0); cyc(1, 3, 0); end
    cyc(0, 0, 0); cyc(0, 0, 0);
    check("lock2_on", int'(lockout), 1);
    async_reset_check("rst_mid_lock");
    send_key();
    check("unl_after_rst", int'(unlocked), 1);
    cyc(0, 0, 0);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
